// File: rtl/muldiv_wb_unit.sv
// Iterative RV32M multiply/divide unit that writes its result straight into the register file.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
module muldiv_wb_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wd
);

    // state  | meaning
    // S_IDLE | waiting for start; operands and rd latched on accept
    // S_CALC | one shift-add / restoring-divide step per cycle, then a final result cycle
    // S_WB   | single-cycle register write of wb_wd to wb_rd
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WB} state_t;

    state_t state, state_nx;

    logic [2:0]        f3_q;
    logic              neg_q;
    logic [XLEN-1:0]   op_m;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [CNT_W-1:0]  cnt;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              in_div, div_zero, div_ovf, special, neg_in;
    logic [XLEN-1:0]   special_res;

    assign a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign sa       = a_signed & rs1_val[XLEN-1];
    assign sb       = b_signed & rs2_val[XLEN-1];
    assign mag_a    = sa ? -rs1_val : rs1_val;
    assign mag_b    = sb ? -rs2_val : rs2_val;
    assign in_div   = funct3[2];
    assign div_zero = in_div && (rs2_val == '0);
    assign div_ovf  = in_div && !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2_val == '1);
    assign special  = div_zero || div_ovf;
    // Remainder follows the dividend sign; product and quotient follow sA ^ sB.
    assign neg_in   = (in_div && funct3[1]) ? sa : (sa ^ sb);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? rs1_val : '1;
        else
            special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   quo, remv, calc_res;
    logic              calc_last;

    // Multiply keeps {acc_hi, acc_lo} as the product register with the multiplier in acc_lo;
    // divide keeps the partial remainder in acc_hi and shifts quotient bits into acc_lo.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_m} : {(XLEN+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ok    = div_shift >= {1'b0, op_m};
    assign prod_s    = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    logic               fa_ext, fb_ext;
    logic signed [2*XLEN-1:0] fa, fb;
    // Fast multiplies hold the raw operands; sign-extended to 64 bits this equals the 33x33 product.
    assign fa_ext   = acc_hi[XLEN-1] & ((f3_q == 3'd1) || (f3_q == 3'd2));
    assign fb_ext   = acc_lo[XLEN-1] & (f3_q == 3'd1);
    assign fa       = {{XLEN{fa_ext}}, acc_hi};
    assign fb       = {{XLEN{fb_ext}}, acc_lo};
    assign mul_prod = fa * fb;
`else
    localparam bit FAST_MUL = 1'b0;
    assign mul_prod = prod_s;
`endif

    assign quo       = neg_q ? -acc_lo : acc_lo;
    assign remv      = neg_q ? -acc_hi : acc_hi;
    assign calc_res  = f3_q[2] ? (f3_q[1] ? remv : quo)
                     : ((f3_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN]);
    // The cycle after the last iteration applies the sign fix-up and loads wb_wd.
    assign calc_last = (cnt == CNT_W'(XLEN)) || (FAST_MUL && !f3_q[2]);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = special ? S_WB : S_CALC;
            S_CALC: if (calc_last) state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q   <= '0;
            neg_q  <= 1'b0;
            op_m   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            wb_rd  <= '0;
            wb_wd  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f3_q   <= funct3;
                        neg_q  <= neg_in;
                        wb_rd  <= rd_in;
                        cnt    <= '0;
                        acc_hi <= '0;
                        if (special)
                            wb_wd <= special_res;
                        if (!in_div) begin
                            op_m   <= mag_a;
                            acc_lo <= mag_b;
                            if (FAST_MUL) begin
                                acc_hi <= rs1_val;
                                acc_lo <= rs2_val;
                            end
                        end else begin
                            op_m   <= mag_b;
                            acc_lo <= mag_a;
                        end
                    end
                end
                S_CALC: begin
                    if (calc_last) begin
                        wb_wd <= calc_res;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (f3_q[2]) begin
                            acc_hi <= div_ok ? XLEN'(div_shift - {1'b0, op_m}) : div_shift[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], div_ok};
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_WB);
    assign wb_we = (state == S_WB) && (wb_rd != 5'd0);

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Scoreboard bench for muldiv_wb_unit: expected writes queued at issue, checked at wb_we.
// Honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_wb_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        busy, done, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;

    muldiv_wb_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
        .busy(busy), .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int we_cnt   = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, zb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'({{32{a[31]}}, a});
        sb  = longint'({{32{b[31]}}, b});
        zb  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (wb_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("queue_level_at_write", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wb_rd", 64'(wb_rd), 64'(exp_e[36:32]));
                    check("wb_wd", 64'(wb_wd), 64'(exp_e[31:0]));
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke);
        int cyc, d0, exp_lat;
        bit spec;
        d0   = done_cnt;
        spec = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = spec ? 1 : ((!f[2] && FAST) ? 2 : 34);
        @(negedge clk);
        funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        if (rd != 0) exp_q.push_back({rd, model(f, a, b)});
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) check("busy_after_start", 64'(busy), 64'd1);
            if (poke && cyc == 1) begin
                funct3 = 3'd5; rs1_val = 32'd50; rs2_val = 32'd0; rd_in = 5'd7; start = 1'b1;
            end
        end while (!done && cyc < 100);
        check("latency", 64'(cyc), 64'(exp_lat));
        @(negedge clk);
        check("busy_after_wb", 64'(busy), 64'd0);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, w0;
        rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_wd", 64'(wb_wd), 64'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'd6, 5'd5, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 5'd8, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 5'd9, 1'b0);
        run_op(3'd5, 32'd123, 32'd0, 5'd10, 1'b0);
        run_op(3'd6, 32'd5, 32'd0, 5'd11, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);

        // rd = x0 with a second start poked in during CALC
        d0 = done_cnt; w0 = we_cnt;
        run_op(3'd0, 32'd11, 32'd13, 5'd0, 1'b1);
        repeat (40) @(negedge clk);
        check("x0_no_write", 64'(we_cnt - w0), 64'd0);
        check("ignored_start_done", 64'(done_cnt - d0), 64'd1);

        // reset in the middle of a divide
        d0 = done_cnt; w0 = we_cnt;
        @(negedge clk);
        funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd14; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy",  64'(busy),  64'd0);
        check("rst_mid_done",  64'(done),  64'd0);
        check("rst_mid_wb_we", 64'(wb_we), 64'd0);
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_mid_no_write", 64'(we_cnt - w0), 64'd0);
        run_op(3'd0, 32'd3, 32'd3, 5'd15, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = (i % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom();
            if (i % 3 == 0) a = -a;
            run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(1, 31)), 1'b0);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
